// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: central sequencer for the snake game.
// Runs the IDLE/PLAY/OVER state machine, generates the move tick, and turns collision
// results into grow, food-respawn, length and score updates. The move period shrinks
// by BOOST_STEP on every consumed bite, down to MIN_DIV.
//
// Ports:
//   clk_i        system clock
//   reset_i      asynchronous active-high reset
//   start_i      restart request level (synchronized upstream, edge-detected here)
//   bite_i       head on food
//   dead_i       head on wall or body
//   init_o       one-cycle pulse: reload snake/food start positions
//   move_en_o    one-cycle pulse: advance snake one cell
//   grow_o       one-cycle pulse with move_en_o: append a segment
//   food_clr_o   one-cycle pulse with move_en_o: respawn food
//   length_o     current segment count
//   score_o      foods eaten, saturating at 255
//   state_o      IDLE=0, PLAY=1, OVER=2
//   game_over_o  high while in OVER
module snake_game_ctrl #(
  parameter int unsigned TICK_DIV   = 2_500_000,
  parameter int unsigned MIN_DIV    = 500_000,
  parameter int unsigned BOOST_STEP = 100_000,
  parameter int unsigned INIT_LEN   = 3,
  parameter int unsigned MAX_LEN    = 32,
  parameter int unsigned HOLD_TICKS = 40
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       bite_i,
  input  logic       dead_i,
  output logic       init_o,
  output logic       move_en_o,
  output logic       grow_o,
  output logic       food_clr_o,
  output logic [5:0] length_o,
  output logic [7:0] score_o,
  output logic [1:0] state_o,
  output logic       game_over_o
);

  localparam int unsigned HoldW = (HOLD_TICKS < 1) ? 1 : $clog2(HOLD_TICKS + 1);

  localparam logic [23:0]      TickDiv    = 24'(TICK_DIV);
  localparam logic [23:0]      MinDiv     = 24'(MIN_DIV);
  localparam logic [23:0]      Boost      = 24'(BOOST_STEP);
  // One extra bit so MIN_DIV + BOOST_STEP cannot wrap in the floor compare.
  localparam logic [24:0]      BoostFloor = 25'(MIN_DIV) + 25'(BOOST_STEP);
  localparam logic [5:0]       InitLen    = 6'(INIT_LEN);
  localparam logic [5:0]       MaxLen     = 6'(MAX_LEN);
  localparam logic [HoldW-1:0] HoldMax    = HoldW'(HOLD_TICKS);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPlay = 2'd1,
    StOver = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [23:0]      counter_q, counter_d;
  logic [23:0]      period_q, period_d;
  logic [5:0]       length_q, length_d;
  logic [7:0]       score_q, score_d;
  logic             bite_pend_q, bite_pend_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             start_q;
  logic             game_over_q, game_over_d;
  logic             init_q, init_d;
  logic             move_en_q, move_en_d;
  logic             grow_q, grow_d;
  logic             food_clr_q, food_clr_d;

  logic start_edge;
  logic do_init;

  assign start_edge = start_i & ~start_q;

  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    period_d    = period_q;
    length_d    = length_q;
    score_d     = score_q;
    bite_pend_d = bite_pend_q;
    hold_d      = hold_q;
    game_over_d = game_over_q;
    init_d      = 1'b0;
    move_en_d   = 1'b0;
    grow_d      = 1'b0;
    food_clr_d  = 1'b0;
    do_init     = 1'b0;

    case (state_q)
      StIdle: begin
        do_init = start_edge;
      end

      StPlay: begin
        if (dead_i) begin
          // dead wins over a coinciding tick or bite; pending bite is dropped.
          state_d     = StOver;
          game_over_d = 1'b1;
          hold_d      = '0;
          counter_d   = period_q - 24'd1;
          bite_pend_d = 1'b0;
        end else if (counter_q == '0) begin
          move_en_d = 1'b1;
          // Reload with the period in force before any speed-up from this tick.
          counter_d = period_q - 24'd1;
          if (bite_i || bite_pend_q) begin
            grow_d      = (length_q < MaxLen);
            food_clr_d  = 1'b1;
            length_d    = (length_q < MaxLen) ? length_q + 6'd1 : length_q;
            score_d     = (score_q != 8'hFF) ? score_q + 8'd1 : score_q;
            period_d    = ({1'b0, period_q} < BoostFloor) ? MinDiv : period_q - Boost;
            bite_pend_d = 1'b0;
          end
        end else begin
          counter_d = counter_q - 24'd1;
          if (bite_i) begin
            bite_pend_d = 1'b1;
          end
        end
      end

      StOver: begin
        if ((hold_q == HoldMax) && start_edge) begin
          do_init = 1'b1;
        end else if (counter_q == '0) begin
          counter_d = period_q - 24'd1;
          if (hold_q != HoldMax) begin
            hold_d = hold_q + 1'b1;
          end
        end else begin
          counter_d = counter_q - 24'd1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    if (do_init) begin
      state_d     = StPlay;
      init_d      = 1'b1;
      game_over_d = 1'b0;
      length_d    = InitLen;
      score_d     = '0;
      period_d    = TickDiv;
      counter_d   = TickDiv - 24'd1;
      bite_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      counter_q   <= TickDiv - 24'd1;
      period_q    <= TickDiv;
      length_q    <= InitLen;
      score_q     <= '0;
      bite_pend_q <= 1'b0;
      hold_q      <= '0;
      start_q     <= 1'b0;
      game_over_q <= 1'b0;
      init_q      <= 1'b0;
      move_en_q   <= 1'b0;
      grow_q      <= 1'b0;
      food_clr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      period_q    <= period_d;
      length_q    <= length_d;
      score_q     <= score_d;
      bite_pend_q <= bite_pend_d;
      hold_q      <= hold_d;
      start_q     <= start_i;
      game_over_q <= game_over_d;
      init_q      <= init_d;
      move_en_q   <= move_en_d;
      grow_q      <= grow_d;
      food_clr_q  <= food_clr_d;
    end
  end

  assign init_o      = init_q;
  assign move_en_o   = move_en_q;
  assign grow_o      = grow_q;
  assign food_clr_o  = food_clr_q;
  assign length_o    = length_q;
  assign score_o     = score_q;
  assign state_o     = state_q;
  assign game_over_o = game_over_q;

endmodule

// File: doc/snake_game_ctrl.md
# snake_game_ctrl

Central sequencer for the snake game. Runs the IDLE/PLAY/OVER state machine, generates the move tick that advances the snake, and turns collision results (bite, dead) into grow, food-respawn, length and score updates. Move speed rises with every bite. Sits between the collision checker and the snake/food position blocks, and replaces the free-running pacemaker as the single source of movement timing.

## Interface
Parameters:
- TICK_DIV, 2_500_000: initial move period in clk cycles (20 Hz at 50 MHz); must fit in 24 bits and be at least 2.
- MIN_DIV, 500_000: floor of the move period; must be at least 2.
- BOOST_STEP, 100_000: amount the period shrinks on each bite.
- INIT_LEN, 3: snake length after init; range 1..MAX_LEN.
- MAX_LEN, 32: maximum number of segments.
- HOLD_TICKS, 40: number of periods in OVER before a restart is accepted.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high; forces every register to its reset value.
- start  in  1  restart request level, already synchronized upstream; the block edge-detects it internally.
- bite  in  1  head on food (from collision).
- dead  in  1  head on wall or body (from collision).
- init  out  1  one-cycle pulse telling snake/food blocks to reload their start positions.
- move_en  out  1  one-cycle pulse: advance snake one cell.
- grow  out  1  one-cycle pulse, only ever coincident with move_en: append a segment.
- food_clr  out  1  one-cycle pulse: respawn food.
- length  out  6  current segment count.
- score  out  8  foods eaten, saturating.
- state  out  2  IDLE=0, PLAY=1, OVER=2.
- game_over  out  1  high while in OVER.

## Operation
- Reset values:
  - state=IDLE; init, move_en, grow, food_clr and game_over all 0.
  - length=INIT_LEN, score=0.
  - period=TICK_DIV, counter=TICK_DIV-1.
  - bite_pend=0, hold=0, start_q=0.
- All outputs are registered.
- start edge = start & ~start_q.
- IDLE: wait for a start edge.
  - On the edge: go to PLAY; pulse init; set length=INIT_LEN, score=0, period=TICK_DIV, counter=TICK_DIV-1; clear bite_pend.
- PLAY:
  - counter decrements every cycle.
  - At counter==0: pulse move_en and reload counter=period-1.
  - bite high on any PLAY cycle sets bite_pend.
  - On a move_en cycle with bite_pend=1, in the same cycle:
    - grow=1, but only if length<MAX_LEN;
    - food_clr=1;
    - length+=1, saturating at MAX_LEN;
    - score+=1, saturating at 255;
    - period=max(period-BOOST_STEP, MIN_DIV);
    - bite_pend cleared.
  - The reload in that same cycle uses the old period; the new period applies from the next reload.
  - Period arithmetic is 24-bit. Compare period-BOOST_STEP against MIN_DIV without unsigned wrap: if period < MIN_DIV+BOOST_STEP, the result is MIN_DIV.
- dead high in PLAY:
  - Next state is OVER, game_over=1, hold=0, counter=period-1; bite_pend discarded.
  - No move_en, grow or food_clr is issued on the dead cycle or after it.
- OVER:
  - counter keeps running; each wrap increments hold, saturating at HOLD_TICKS.
  - bite and dead are ignored.
  - Start edges are ignored while hold<HOLD_TICKS.
  - Once hold==HOLD_TICKS, a start edge performs the same init sequence as in IDLE, enters PLAY and clears game_over.
- reset asserted in any state or mid-pulse returns every register to its reset value immediately; no pulse is completed.

## Timing
- init is high in the first PLAY cycle (cycle N+1 when the start edge is sampled at N).
- The first move_en falls exactly TICK_DIV cycles after init. Subsequent move_en pulses are spaced by the current period.
- grow and food_clr are high in the same cycle as move_en, never alone.
- bite latency: a bite seen any time before or on the cycle counter==0 is consumed at that move_en.
- length and score update in the cycle after the move_en edge, i.e. they are visible together with the registered pulse.
- Simultaneous events:
  - dead and counter==0 in the same cycle: dead wins, no move_en.
  - bite and dead in the same cycle: dead wins, score unchanged.
  - start during PLAY: ignored.

## Test plan
All scenarios use TICK_DIV=10, MIN_DIV=4, BOOST_STEP=3, INIT_LEN=3, MAX_LEN=32, HOLD_TICKS=2.
- Reset then start edge at cycle 5 -> init high at cycle 6, state=1; move_en at cycles 16, 26, 36; length=3, score=0.
- Bite pulse at cycle 20 -> grow and food_clr high at cycle 26 only; length=4, score=1; next move_en at 36, then 43 (period 7), then 50.
- Four consumed bites -> period sequence 7, 4, 4, 4; the floor holds with no wrap.
- Length at 32 plus a bite -> food_clr=1, grow=0, length stays 32, score increments.
- dead asserted on the same cycle counter==0 while bite_pend=1:
  - no move_en, state=2, game_over=1;
  - a start edge 5 cycles later is ignored;
  - a start edge after 2 periods triggers init, state=1, length=3, score=0.
- reset asserted mid-PLAY, on a move_en cycle -> all outputs return to reset values in the same cycle; state=0.
